// File: rtl/prog_rom_pkg.sv
// prog_rom_pkg: shared types and default geometry for the program ROM.
//   state_e   - load FSM states (IDLE, LOAD)
//   DW_DEF    - default data word width
//   AW_DEF    - default address width
//   DEPTH_DEF - default number of stored words
package prog_rom_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/prog_rom_ram.sv
// prog_rom_ram: DEPTH x DW storage with one synchronous write port and one
// synchronous read port. Read data is registered inside and holds its value
// whenever re_i is low.
//   clk     - clock
//   we_i    - write enable
//   waddr_i - write address (must be < DEPTH when we_i is high)
//   wdata_i - write data
//   re_i    - read enable
//   raddr_i - read address (must be < DEPTH when re_i is high)
//   rdata_o - registered read data
module prog_rom_ram
  import prog_rom_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Index width actually needed to address DEPTH words.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Upper address bits are never needed because callers keep addresses
  // below DEPTH; fold them into a sink so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i, raddr_i};

  // NOTE: the array has no reset on purpose -- contents must survive rst,
  // and a reset on a memory array prevents mapping it onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i[IW-1:0]] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i[IW-1:0]];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_rom.sv
// prog_rom: loadable program ROM. A load streams ld_len words (clipped to
// DEPTH) into consecutive addresses from 0; outside a load, reads return
// the stored word one cycle after rd with dvalid, or zero with aerr when
// the address is out of range.
//   clk, rst             - clock, synchronous active-high reset
//   adrs, rd             - read address and read request
//   dout, dvalid, aerr   - read data, response valid, address error
//   ld_start, ld_len     - start a load of ld_len words
//   ld_data, ld_valid    - load word stream
//   busy, ld_done        - load in progress, load-complete pulse
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] adrs,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          aerr,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          busy,
  output logic          ld_done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   len_clip;
  logic          done_q, done_d;
  logic          dvalid_q, aerr_q;
  logic          zero_q;
  logic          we, rd_acc, in_range;
  logic [DW-1:0] ram_rdata;

  assign len_clip = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;
  assign in_range = {1'b0, adrs} < DEPTH_W;
  // A pending ld_start wins over rd; rst blocks both reads and writes.
  assign rd_acc   = rd && (state_q == IDLE) && !ld_start && !rst;
  assign we       = ld_valid && (state_q == LOAD) && !rst;

  // State register.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and load-counter logic.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          len_d = len_clip;
          cnt_d = '0;
          // A zero-length load completes immediately without entering LOAD.
          if (len_clip == '0) done_d  = 1'b1;
          else                state_d = LOAD;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy = (state_q == LOAD);
  end

  // Counter, completion pulse and read-response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      dvalid_q <= rd_acc;
      aerr_q   <= rd_acc && !in_range;
      // zero_q remembers whether the last response was forced to zero, so
      // dout keeps holding 0 after an out-of-range read or reset.
      if (rd_acc) zero_q <= !in_range;
    end
  end

  prog_rom_ram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (ld_data),
    .re_i    (rd_acc && in_range),
    .raddr_i (adrs),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is the data register; only in-range reads update
  // it, so it holds across idle cycles and out-of-range reads.
  assign dout    = zero_q ? '0 : ram_rdata;
  assign dvalid  = dvalid_q;
  assign aerr    = aerr_q;
  assign ld_done = done_q;

endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: directed stimulus for prog_rom with a read-response
// scoreboard. Issued reads push their expected data/aerr/cycle; a monitor
// on the falling edge pops and compares whenever dvalid is high.
module tb_prog_rom;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] adrs;
  logic          rd;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          aerr;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          busy;
  logic          ld_done;

  prog_rom #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .adrs     (adrs),
    .rd       (rd),
    .dout     (dout),
    .dvalid   (dvalid),
    .aerr     (aerr),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .busy     (busy),
    .ld_done  (ld_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  int   busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts ld_done/busy cycles and scores read responses.
  always @(negedge clk) begin
    exp_t e;
    if (ld_done === 1'b1) done_seen++;
    if (busy === 1'b1) busy_seen++;
    if (dvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_dvalid", 32'(dvalid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rd_latency", 32'(cyc), 32'(e.cyc));
        check("rd_dout", 32'(dout), 32'(e.data));
        check("rd_aerr", 32'(aerr), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd       = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Leaves rd high so consecutive calls are back-to-back reads.
  task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    exp_t x;
    rd    = 1'b1;
    adrs  = a;
    x.data = d;
    x.err  = e;
    x.cyc  = cyc + 1;
    sb_q.push_back(x);
    tick();
  endtask

  task automatic start_load(input int len);
    ld_start = 1'b1;
    ld_len   = (AW+1)'(len);
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic v);
    ld_data  = d;
    ld_valid = v;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wa [4];
    int d0, b0;
    wa = '{8'h01, 8'h01, 8'h05, 8'h21};

    rst = 1'b1; rd = 1'b0; adrs = '0; ld_start = 1'b0;
    ld_len = '0; ld_data = '0; ld_valid = 1'b0;
    tick(); tick();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_aerr", 32'(aerr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    rst = 1'b0;
    idle(1);

    // Basic 4-word load, then back-to-back reads.
    d0 = done_seen; b0 = busy_seen;
    start_load(4);
    check("a_busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send_word(wa[i], 1'b1);
    check("a_ld_done", 32'(ld_done), 32'd1);
    check("a_busy_off", 32'(busy), 32'd0);
    idle(1);
    check("a_ld_done_clr", 32'(ld_done), 32'd0);
    check("a_done_count", 32'(done_seen - d0), 32'd1);
    check("a_busy_cycles", 32'(busy_seen - b0), 32'd4);
    for (int i = 0; i < 4; i++) issue_read(AW'(i), wa[i], 1'b0);
    idle(2);

    // Load with ld_valid gaps: counter holds, done only after 3rd word.
    d0 = done_seen;
    start_load(3);
    send_word(8'hAA, 1'b1);
    send_word(8'h5A, 1'b0);
    check("b_busy_gap", 32'(busy), 32'd1);
    send_word(8'h5A, 1'b0);
    send_word(8'hBB, 1'b1);
    check("b_no_done_early", 32'(done_seen - d0), 32'd0);
    check("b_busy_before_last", 32'(busy), 32'd1);
    send_word(8'hCC, 1'b1);
    check("b_ld_done", 32'(ld_done), 32'd1);
    idle(1);
    check("b_done_count", 32'(done_seen - d0), 32'd1);
    issue_read(8'd0, 8'hAA, 1'b0);
    issue_read(8'd1, 8'hBB, 1'b0);
    issue_read(8'd2, 8'hCC, 1'b0);
    idle(2);

    // rd together with ld_start, then rd during LOAD: never accepted.
    rd = 1'b1; adrs = 8'd0; ld_start = 1'b1; ld_len = 9'd1;
    tick();
    rd = 1'b0; ld_start = 1'b0;
    check("c_start_wins_dvalid", 32'(dvalid), 32'd0);
    check("c_start_wins_busy", 32'(busy), 32'd1);
    rd = 1'b1; adrs = 8'd1;
    tick();
    rd = 1'b0;
    check("c_rd_in_load_dvalid", 32'(dvalid), 32'd0);
    send_word(8'h77, 1'b1);
    check("c_ld_done", 32'(ld_done), 32'd1);
    idle(1);
    issue_read(8'd0, 8'h77, 1'b0);
    idle(2);

    // Out-of-range reads and dout hold when idle.
    issue_read(8'h20, 8'h00, 1'b1);
    issue_read(8'h00, 8'h77, 1'b0);
    issue_read(8'hFF, 8'h00, 1'b1);
    issue_read(8'h01, 8'hBB, 1'b0);
    idle(3);
    check("d_dout_hold", 32'(dout), 32'hBB);
    check("d_dvalid_idle", 32'(dvalid), 32'd0);
    check("d_aerr_idle", 32'(aerr), 32'd0);

    // Reset mid-load (same cycle as a valid word): abort, keep written words.
    d0 = done_seen;
    start_load(4);
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    ld_data = 8'h33; ld_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ld_valid = 1'b0;
    check("e_busy_after_rst", 32'(busy), 32'd0);
    check("e_ld_done_after_rst", 32'(ld_done), 32'd0);
    check("e_dout_after_rst", 32'(dout), 32'd0);
    idle(2);
    check("e_no_done", 32'(done_seen - d0), 32'd0);
    issue_read(8'd0, 8'h11, 1'b0);
    issue_read(8'd1, 8'h22, 1'b0);
    issue_read(8'd2, 8'hCC, 1'b0);
    issue_read(8'd3, 8'h21, 1'b0);
    idle(2);

    // Zero-length load: immediate done, never busy.
    d0 = done_seen; b0 = busy_seen;
    start_load(0);
    check("f_len0_done", 32'(ld_done), 32'd1);
    check("f_len0_busy", 32'(busy), 32'd0);
    idle(1);
    check("f_len0_done_clr", 32'(ld_done), 32'd0);
    check("f_len0_done_count", 32'(done_seen - d0), 32'd1);
    check("f_len0_busy_cycles", 32'(busy_seen - b0), 32'd0);

    // Oversize load (40 > DEPTH): clipped to 32 writes.
    d0 = done_seen; b0 = busy_seen;
    start_load(40);
    for (int i = 0; i < 32; i++) begin
      send_word(8'(i * 7 + 3), 1'b1);
      if (i == 30) check("f_busy_at_31", 32'(busy), 32'd1);
    end
    check("f_clip_done", 32'(ld_done), 32'd1);
    check("f_clip_busy_off", 32'(busy), 32'd0);
    send_word(8'hEE, 1'b1);
    idle(1);
    check("f_clip_busy_cycles", 32'(busy_seen - b0), 32'd32);
    check("f_clip_done_count", 32'(done_seen - d0), 32'd1);
    issue_read(8'd0, 8'h03, 1'b0);
    issue_read(8'd5, 8'h26, 1'b0);
    issue_read(8'd31, 8'hDC, 1'b0);
    issue_read(8'd32, 8'h00, 1'b1);
    idle(2);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_rom.md
PROG_ROM -- requirements
Module: prog_rom

Interface
REQ-001 Parameter DW, default 8: data word width in bits.
REQ-002 Parameter AW, default 8: address width in bits.
REQ-003 Parameter DEPTH, default 32: number of stored words, 1..2**AW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 adrs  input  AW  read address.
REQ-007 rd  input  1  read request, sampled on rising edge.
REQ-008 dout  output  DW  registered read data.
REQ-009 dvalid  output  1  dout holds the response to an accepted rd.
REQ-010 aerr  output  1  the accepted read addressed a location >= DEPTH.
REQ-011 ld_start  input  1  begin program load.
REQ-012 ld_len  input  AW+1  number of words to load, sampled with ld_start.
REQ-013 ld_data  input  DW  load word.
REQ-014 ld_valid  input  1  ld_data is valid this cycle.
REQ-015 busy  output  1  high while in LOAD.
REQ-016 ld_done  output  1  one-cycle pulse when a load completes.

Function
REQ-017 The FSM SHALL have two states: IDLE and LOAD.
REQ-018 In IDLE, ld_start=1 SHALL latch L=min(ld_len,DEPTH), clear the load counter, and enter LOAD; if L=0, it SHALL pulse ld_done next cycle and stay in IDLE.
REQ-019 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to address counter and increment the counter; ld_valid=0 SHALL hold the counter.
REQ-020 The write that makes the counter equal L SHALL cause a return to IDLE and an ld_done pulse in the following cycle.
REQ-021 ld_start SHALL be ignored in LOAD, and ld_valid SHALL be ignored in IDLE.
REQ-022 A read SHALL be accepted only when rd=1, the state is IDLE, and ld_start=0; ld_start wins a simultaneous rd.
REQ-023 An accepted read SHALL update dout with mem[adrs] and set dvalid=1 exactly one cycle later (latency 1).
REQ-024 Back-to-back reads SHALL sustain one word per cycle.
REQ-025 When no read is accepted, dvalid SHALL be 0 next cycle and dout SHALL hold its last value.
REQ-026 An accepted read with adrs >= DEPTH SHALL return dout=0 with dvalid=1 and aerr=1; aerr SHALL otherwise be 0.
REQ-027 busy SHALL equal (state==LOAD) combinationally from the state register.
REQ-028 Memory contents SHALL change only through load writes and SHALL persist across rst.

Reset
REQ-029 rst=1 SHALL set state=IDLE, load counter=0, dout=0, dvalid=0, aerr=0, and ld_done=0 on the next edge.
REQ-030 rst during LOAD SHALL abort the load without an ld_done pulse and SHALL retain the words already written.
REQ-031 rst SHALL override all other inputs in the same cycle.

Structure
REQ-032 Package prog_rom_pkg SHALL hold the state enum (IDLE, LOAD) and the default DW/AW/DEPTH constants.
REQ-033 The storage array SHALL be a sub-module, prog_rom_ram: one synchronous write port and one synchronous read port, DEPTH x DW, with no reset.
REQ-034 The FSM, load counter, and output registers SHALL reside in prog_rom.

Verification
REQ-035 Reset, then ld_start with ld_len=4 and words 01,01,05,21 on consecutive ld_valid -> busy high for 4 cycles, ld_done pulse once; reads of adrs 0..3 -> 01,01,05,21, each 1 cycle after rd.
REQ-036 Load with ld_valid gaps (1,0,0,1,1) -> counter holds during gaps; ld_done only after the 3rd valid word.
REQ-037 rd and ld_start in the same cycle -> no dvalid next cycle; rd during LOAD -> dvalid stays 0.
REQ-038 rd with adrs=8'h20 and DEPTH=32 -> dout=0, dvalid=1, aerr=1; a following rd with adrs=0 -> aerr=0.
REQ-039 rst asserted after 2 of 4 load words -> state IDLE, no ld_done; reads of adrs 0..1 return the new words, adrs 2..3 return the old contents.
REQ-040 ld_len=0 -> ld_done pulse next cycle, busy never high; ld_len=40 with DEPTH=32 -> exactly 32 writes, then ld_done.
